// File: rtl/ps2_pkg.sv
// ps2_pkg: state encoding and 50 MHz timing defaults for the PS/2 host transmitter
package ps2_pkg;
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      INHIBIT  = 4'd1,
      RTS      = 4'd2,
      DATA     = 4'd3,
      PARITY   = 4'd4,
      STOP     = 4'd5,
      ACK      = 4'd6,
      COMPLETE = 4'd7,
      ERROR    = 4'd8
   } state_t;
   localparam int DEF_CLK_FREQ_HZ          = 50_000_000;
   localparam int DEF_CYCLES_INHIBIT       = 5_050;
   localparam int DEF_CYCLES_START_TIMEOUT = 750_000;
   localparam int DEF_CYCLES_XFER_TIMEOUT  = 100_000;
   localparam int DEF_TIMER_W              = 20;
   // Rescales a 50 MHz cycle count to another clock frequency
   function automatic int scale_cycles(input int cycles_50m, input int clk_hz);
      return int'(longint'(cycles_50m) * longint'(clk_hz) / longint'(DEF_CLK_FREQ_HZ));
   endfunction
endpackage

// File: rtl/ps2_command_out_if.sv
// ps2_command_out_if: command handshake plus synchronised PS/2 line events and drive enables
interface ps2_command_out_if;
   logic [7:0] the_command;
   logic       send_command;
   logic       ps2_clk_posedge;
   logic       ps2_clk_negedge;
   logic       ps2_data;
   logic       ps2_clk_drive_low;
   logic       ps2_data_drive_low;
   logic       busy;
   logic       command_was_sent;
   logic       error_timed_out;
   modport master (
      output the_command, send_command, ps2_clk_posedge, ps2_clk_negedge, ps2_data,
      input  ps2_clk_drive_low, ps2_data_drive_low, busy, command_was_sent, error_timed_out
   );
   modport slave (
      input  the_command, send_command, ps2_clk_posedge, ps2_clk_negedge, ps2_data,
      output ps2_clk_drive_low, ps2_data_drive_low, busy, command_was_sent, error_timed_out
   );
endinterface

// File: rtl/ps2_tx_timer.sv
// ps2_tx_timer: loadable down-counter; expired flags the last enabled cycle before it hits zero
module ps2_tx_timer #(
   parameter int TIMER_W = 20
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               enable,
   input  logic [TIMER_W-1:0] value,
   output logic               expired
);
   logic [TIMER_W-1:0] count;
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (load) count <= value;
      else if (enable && count != '0) count <= count - TIMER_W'(1);
   assign expired = enable && count <= TIMER_W'(1);
endmodule

// File: rtl/ps2_command_out.sv
// ps2_command_out: host-to-device PS/2 transmitter (inhibit, RTS, 8 data bits, odd parity, stop, ack)
module ps2_command_out import ps2_pkg::*; #(
   parameter int CLK_FREQ_HZ          = DEF_CLK_FREQ_HZ,
   parameter int CYCLES_INHIBIT       = scale_cycles(DEF_CYCLES_INHIBIT, CLK_FREQ_HZ),
   parameter int CYCLES_START_TIMEOUT = scale_cycles(DEF_CYCLES_START_TIMEOUT, CLK_FREQ_HZ),
   parameter int CYCLES_XFER_TIMEOUT  = scale_cycles(DEF_CYCLES_XFER_TIMEOUT, CLK_FREQ_HZ),
   parameter int TIMER_W              = DEF_TIMER_W
) (
   input logic              clk,
   input logic              reset,
   ps2_command_out_if.slave bus
);
   state_t             state;
   logic [7:0]         data_q;
   logic               parity_q;
   logic [2:0]         bit_cnt;
   logic               tmr_load, tmr_en, tmr_exp, edge_hit, abort;
   logic [TIMER_W-1:0] tmr_val;
   // Only the transitions into INHIBIT, RTS and DATA reload; the transfer budget spans DATA..ACK
   always_comb begin
      tmr_load = (state == IDLE && bus.send_command) || (state == INHIBIT && tmr_exp) ||
                 (state == RTS && bus.ps2_clk_negedge);
      tmr_val  = state == IDLE    ? TIMER_W'(CYCLES_INHIBIT) :
                 state == INHIBIT ? TIMER_W'(CYCLES_START_TIMEOUT) : TIMER_W'(CYCLES_XFER_TIMEOUT);
      tmr_en   = state != IDLE && state != COMPLETE && state != ERROR;
      edge_hit = state == ACK ? bus.ps2_clk_posedge : bus.ps2_clk_negedge;
      abort    = (state inside {RTS, DATA, PARITY, STOP, ACK}) &&
                 (edge_hit ? (state == ACK && bus.ps2_data) : tmr_exp);
   end
   ps2_tx_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk(clk), .reset(reset), .load(tmr_load), .enable(tmr_en), .value(tmr_val), .expired(tmr_exp)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                  <= IDLE;
         data_q                 <= '0;
         parity_q               <= 1'b0;
         bit_cnt                <= '0;
         bus.ps2_clk_drive_low  <= 1'b0;
         bus.ps2_data_drive_low <= 1'b0;
         bus.busy               <= 1'b0;
         bus.command_was_sent   <= 1'b0;
         bus.error_timed_out    <= 1'b0;
      end else if (abort) begin
         state                  <= ERROR;
         bus.ps2_clk_drive_low  <= 1'b0;
         bus.ps2_data_drive_low <= 1'b0;
         bus.error_timed_out    <= 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.send_command) begin
               state                 <= INHIBIT;
               data_q                <= bus.the_command;
               parity_q              <= ~^bus.the_command;
               bus.busy              <= 1'b1;
               bus.ps2_clk_drive_low <= 1'b1;
            end
            INHIBIT: if (tmr_exp) begin
               state                  <= RTS;
               bus.ps2_clk_drive_low  <= 1'b0;
               bus.ps2_data_drive_low <= 1'b1;
            end
            RTS: if (edge_hit) begin
               state                  <= DATA;
               bit_cnt                <= '0;
               bus.ps2_data_drive_low <= ~data_q[0];
            end
            DATA: if (edge_hit) begin
               bit_cnt                <= bit_cnt + 3'd1;
               bus.ps2_data_drive_low <= bit_cnt == 3'd7 ? ~parity_q : ~data_q[bit_cnt + 3'd1];
               if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: if (edge_hit) begin
               state                  <= STOP;
               bus.ps2_data_drive_low <= 1'b0;
            end
            STOP: if (edge_hit) state <= ACK;
            ACK: if (edge_hit) begin
               state                <= COMPLETE;
               bus.command_was_sent <= 1'b1;
            end
            default: if (!bus.send_command) begin
               state                <= IDLE;
               bus.busy             <= 1'b0;
               bus.command_was_sent <= 1'b0;
               bus.error_timed_out  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ps2_command_out.sv
// tb_ps2_command_out: directed frames against a bench-side frame model with a per-cycle output compare
module tb_ps2_command_out;
   import ps2_pkg::*;
   localparam int INH = 20, START = 200, XFER = 400;
   logic clk = 1'b0;
   logic reset;
   logic chk_en = 1'b0;
   logic e_clk, e_data, e_busy, e_sent, e_err;
   int   n_cmp = 0, n_bad = 0;
   ps2_command_out_if bus();
   ps2_command_out #(
      .CYCLES_INHIBIT(INH), .CYCLES_START_TIMEOUT(START), .CYCLES_XFER_TIMEOUT(XFER), .TIMER_W(20)
   ) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame position i: 0..7 data LSB first, 8 odd parity
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      int ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(b[k]);
      if (i < 8) return b[i];
      return (ones % 2) == 0;
   endfunction

   always @(negedge clk)
      if (chk_en)
         check("outputs{clk_dl,data_dl,busy,sent,err}",
               {27'd0, bus.ps2_clk_drive_low, bus.ps2_data_drive_low, bus.busy, bus.command_was_sent, bus.error_timed_out},
               {27'd0, e_clk, e_data, e_busy, e_sent, e_err});

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic c, input logic d, input logic b, input logic s, input logic e);
      e_clk = c; e_data = d; e_busy = b; e_sent = s; e_err = e;
   endtask

   task automatic pulse_neg();
      bus.ps2_clk_negedge = 1'b1;
      tick();
      bus.ps2_clk_negedge = 1'b0;
   endtask

   task automatic pulse_pos();
      bus.ps2_clk_posedge = 1'b1;
      tick();
      bus.ps2_clk_posedge = 1'b0;
   endtask

   task automatic start_frame(input logic [7:0] cmd);
      int low = 0;
      bus.the_command  = cmd;
      bus.send_command = 1'b1;
      tick();
      set_exp(1, 0, 1, 0, 0);
      bus.the_command = ~cmd;
      for (int i = 0; i < INH; i++) begin
         low += int'(bus.ps2_clk_drive_low);
         tick();
      end
      set_exp(0, 1, 1, 0, 0);
      check("inhibit_cycles", low, INH);
   endtask

   task automatic data_bits(input logic [7:0] cmd, input int n, output logic [8:0] obs);
      obs = '0;
      tick(3);
      for (int i = 0; i < n; i++) begin
         pulse_neg();
         e_data = ~frame_bit(cmd, i);
         obs[i] = ~bus.ps2_data_drive_low;
         tick();
         pulse_pos();
         tick();
      end
   endtask

   task automatic finish_frame(input logic ack_data);
      pulse_neg();
      e_data = 1'b0;
      tick();
      pulse_pos();
      tick();
      pulse_neg();
      tick(2);
      bus.ps2_data = ack_data;
      pulse_pos();
      bus.ps2_data = 1'b1;
      if (ack_data) set_exp(0, 0, 1, 0, 1);
      else set_exp(0, 0, 1, 1, 0);
      tick(5);
      bus.send_command = 1'b0;
      tick();
      set_exp(0, 0, 0, 0, 0);
      tick(2);
   endtask

   task automatic full_frame(input logic [7:0] cmd, input logic ack_data, input logic [7:0] lit_byte, input logic lit_par);
      logic [8:0] obs;
      start_frame(cmd);
      data_bits(cmd, 9, obs);
      check("data_bits_lsb_first", {24'd0, obs[7:0]}, {24'd0, lit_byte});
      check("parity_bit", {31'd0, obs[8]}, {31'd0, lit_par});
      finish_frame(ack_data);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] obs;
      reset = 1'b0;
      bus.the_command = '0;
      bus.send_command = 1'b0;
      bus.ps2_clk_posedge = 1'b0;
      bus.ps2_clk_negedge = 1'b0;
      bus.ps2_data = 1'b1;
      set_exp(0, 0, 0, 0, 0);
      tick(3);
      chk_en = 1'b1;
      check("reset_state", {28'd0, dut.state}, {28'd0, IDLE});
      reset = 1'b1;
      tick(2);
      check("model_parity_ED", {31'd0, frame_bit(8'hED, 8)}, 32'd1);
      check("model_parity_F4", {31'd0, frame_bit(8'hF4, 8)}, 32'd0);
      full_frame(8'hED, 1'b0, 8'hED, 1'b1);
      full_frame(8'h00, 1'b0, 8'h00, 1'b1);
      full_frame(8'hFF, 1'b0, 8'hFF, 1'b1);
      start_frame(8'hAB);
      tick(START - 1);
      check("no_early_timeout", {31'd0, bus.error_timed_out}, 32'd0);
      tick();
      set_exp(0, 0, 1, 0, 1);
      check("start_timeout", {29'd0, bus.ps2_clk_drive_low, bus.ps2_data_drive_low, bus.error_timed_out}, 32'd1);
      tick(3);
      bus.send_command = 1'b0;
      tick();
      set_exp(0, 0, 0, 0, 0);
      tick(2);
      full_frame(8'h55, 1'b1, 8'h55, 1'b1);
      start_frame(8'hA5);
      data_bits(8'hA5, 5, obs);
      check("bit4_driven_low", {31'd0, bus.ps2_data_drive_low}, 32'd1);
      #2;
      reset = 1'b0;
      set_exp(0, 0, 0, 0, 0);
      #1;
      check("async_reset_outputs", {27'd0, bus.ps2_clk_drive_low, bus.ps2_data_drive_low, bus.busy,
            bus.command_was_sent, bus.error_timed_out}, 32'd0);
      check("async_reset_state", {28'd0, dut.state}, {28'd0, IDLE});
      bus.send_command = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(2);
      full_frame(8'hF4, 1'b0, 8'hF4, 1'b0);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
